// File: rtl/uart_rx_if.sv
`default_nettype none
// uart_rx_if: serial line and received-byte signals of the UART receiver.
// Rev 1.0
interface uart_rx_if;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       frame_err;

  modport master (output uart_rx, input rx_data, rx_status, frame_err);
  modport slave  (input uart_rx, output rx_data, rx_status, frame_err);
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// uart_rx: 8N1 LSB-first UART receiver with input synchronizer and mid-bit sampling.
// Rev 1.0
module uart_rx #(
  parameter int CLK_DIV     = 5208,
  parameter int SYNC_STAGES = 2
) (
  input  logic     sys_clk,
  input  logic     reset,
  uart_rx_if.slave rx
);

  localparam int            TW       = $clog2(CLK_DIV);
  localparam logic [TW-1:0] HALF_TOP = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] BIT_TOP  = TW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line;
  logic                   line_d;
  state_t                 state;
  logic [TW-1:0]          timer;
  logic [2:0]             bit_idx;
  logic [7:0]             shreg;
  logic                   stop_bad;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx.uart_rx};
    end
  end

  assign line = sync_q[SYNC_STAGES-1];

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      timer        <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      line_d       <= 1'b1;
      stop_bad     <= 1'b0;
      rx.rx_data   <= 8'h00;
      rx.rx_status <= 1'b1;
      rx.frame_err <= 1'b0;
    end else begin
      line_d       <= line;
      rx.rx_status <= 1'b1;
      case (state)
        IDLE: begin
          if (line_d && !line) begin
            state <= START;
            timer <= '0;
          end
        end
        START: begin
          if (timer == HALF_TOP) begin
            timer <= '0;
            if (!line) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (timer == BIT_TOP) begin
            timer          <= '0;
            shreg[bit_idx] <= line;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              stop_bad <= 1'b0;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          // After a bad stop the timer parks at BIT_TOP so the line is
          // re-checked every cycle until it returns high.
          if (timer == BIT_TOP) begin
            if (line) begin
              timer <= '0;
              if (stop_bad) begin
                state <= IDLE;
              end else begin
                state        <= DONE;
                rx.rx_data   <= shreg;
                rx.rx_status <= 1'b0;
                rx.frame_err <= 1'b0;
              end
            end else begin
              stop_bad     <= 1'b1;
              rx.frame_err <= 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          timer <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// tb_uart_rx: planned random/directed line waveform, sample-point reference model, per-cycle compare.
// Rev 1.0
module tb_uart_rx;

  localparam int D    = 16;
  localparam int H    = D / 2 - 1;
  localparam int MAXC = 20000;

  logic sys_clk = 1'b0;
  logic reset;

  uart_rx_if bus ();

  uart_rx #(.CLK_DIV(D), .SYNC_STAGES(2)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .rx      (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  logic       plan_line [MAXC];
  logic       plan_rst  [MAXC];
  int         ev_kind   [MAXC];
  logic [7:0] ev_byte   [MAXC];
  logic [7:0] exp_data  [MAXC];
  logic       exp_stb   [MAXC];
  logic       exp_err   [MAXC];
  int         n_plan = 0;
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  bit         active = 1'b0;

  int f55, fa3, f0f, fgl, fc4, f12, fff, f81;

  task automatic put(input logic v, input int len, input logic r);
    for (int k = 0; k < len; k++) begin
      if (n_plan < MAXC) begin
        plan_line[n_plan] = v;
        plan_rst[n_plan]  = r;
        n_plan++;
      end
    end
  endtask

  task automatic put_frame(input logic [7:0] b, input int bl, input int stop_low);
    put(1'b0, bl, 1'b1);
    for (int j = 0; j < 8; j++) put(b[j], bl, 1'b1);
    if (stop_low > 0) put(1'b0, stop_low, 1'b1);
    else              put(1'b1, bl, 1'b1);
  endtask

  task automatic build_plan();
    int r, bl, fr, k0, len;
    logic [7:0] rb;
    put(1'b1, 4, 1'b0);
    put(1'b1, 10, 1'b1);
    f55 = n_plan; put_frame(8'h55, D, 0); put(1'b1, 20, 1'b1);
    fa3 = n_plan; put_frame(8'hA3, D, 0);
    f0f = n_plan; put_frame(8'h0F, D, 0); put(1'b1, 20, 1'b1);
    fgl = n_plan; put(1'b0, 4, 1'b1); put(1'b1, 40, 1'b1);
    fc4 = n_plan; put_frame(8'hC4, D, 40); put(1'b1, 20, 1'b1);
    f12 = n_plan; put_frame(8'h12, D, 0); put(1'b1, 20, 1'b1);
    fff = n_plan; put_frame(8'hFF, D, 0); put(1'b1, 20, 1'b1);
    for (int t = 0; t < 4; t++) plan_rst[fff + 4*D + 5 + t] = 1'b0;
    f81 = n_plan; put_frame(8'h81, D, 0); put(1'b1, 20, 1'b1);
    put_frame(8'h3C, D - 1, 0); put(1'b1, 30, 1'b1);
    put_frame(8'h3C, D + 1, 0); put(1'b1, 30, 1'b1);
    for (int it = 0; it < 40; it++) begin
      r  = $urandom_range(0, 9);
      rb = 8'($urandom_range(0, 255));
      bl = D;
      case ($urandom_range(0, 5))
        0:       bl = D - 1;
        1:       bl = D + 1;
        default: bl = D;
      endcase
      fr = n_plan;
      if (r <= 6) begin
        put_frame(rb, bl, 0);
        if (r == 6) begin
          k0 = fr + $urandom_range(2, 10*bl - 1);
          plan_line[k0] = ~plan_line[k0];
        end
      end else if (r == 7) begin
        put(1'b0, $urandom_range(1, 12), 1'b1);
        put(1'b1, 20, 1'b1);
      end else if (r == 8) begin
        put_frame(rb, bl, $urandom_range(1, 60));
      end else begin
        put_frame(rb, bl, 0);
        k0  = fr + $urandom_range(0, 10*bl - 6);
        len = $urandom_range(1, 5);
        for (int t = 0; t < len; t++) plan_rst[k0 + t] = 1'b0;
      end
      if ($urandom_range(0, 3) != 0) put(1'b1, $urandom_range(1, 30), 1'b1);
    end
    put(1'b1, 200, 1'b1);
  endtask

  // Line level seen by the receiver, in plan-index terms; the synchronizer holds 1 through reset.
  function automatic logic line_at(input int i, input int lo);
    if (i < lo || i >= n_plan) return 1'b1;
    return plan_line[i];
  endfunction

  // A synchronized fall at plan index F is sampled at F+H+1 (start), F+H+1+D*(j+1) (data j),
  // F+H+1+9D (stop); outcomes appear on the outputs two cycles after their sample index.
  task automatic run_model();
    int lo, hi, i, f, s, k;
    logic [7:0] b, d;
    logic e;
    for (int c = 0; c < n_plan; c++) ev_kind[c] = 0;
    lo = 0;
    while (lo < n_plan) begin
      while (lo < n_plan && !plan_rst[lo]) lo++;
      hi = lo;
      while (hi < n_plan && plan_rst[hi]) hi++;
      i = lo;
      while (1) begin
        f = i;
        while (f + 2 < hi && !(line_at(f - 1, lo) && !line_at(f, lo))) f++;
        if (f + H + 3 >= hi) break;
        if (line_at(f + H + 1, lo)) begin
          i = f + H + 2;
          continue;
        end
        for (int j = 0; j < 8; j++) b[j] = line_at(f + H + 1 + D*(j + 1), lo);
        s = f + H + 1 + 9*D;
        if (s + 2 >= hi) break;
        if (line_at(s, lo)) begin
          ev_kind[s + 2] = 1;
          ev_byte[s + 2] = b;
          i = s + 2;
        end else begin
          ev_kind[s + 2] = 2;
          k = s + 1;
          while (k + 2 < hi && !line_at(k, lo)) k++;
          if (k + 2 >= hi) break;
          i = k + 1;
        end
      end
      lo = hi;
    end
    d = 8'h00;
    e = 1'b0;
    for (int c = 0; c < n_plan; c++) begin
      exp_stb[c] = 1'b0;
      if (!plan_rst[c]) begin
        d = 8'h00;
        e = 1'b0;
      end else if (ev_kind[c] == 1) begin
        d = ev_byte[c];
        e = 1'b0;
        exp_stb[c] = 1'b1;
      end else if (ev_kind[c] == 2) begin
        e = 1'b1;
      end
      exp_data[c] = d;
      exp_err[c]  = e;
    end
  endtask

  task automatic pin(input string name, input int idx, input int kind, input logic [7:0] b);
    checks++;
    if (ev_kind[idx] != kind || (kind == 1 && ev_byte[idx] !== b)) begin
      errors++;
      $display("FAIL model_pin %s: got kind=%0d byte=%h, want kind=%0d byte=%h",
               name, ev_kind[idx], ev_byte[idx], kind, b);
    end
  endtask

  task automatic pin_quiet(input string name, input int lo, input int len);
    int cnt;
    cnt = 0;
    for (int c = lo; c < lo + len; c++) if (ev_kind[c] == 1) cnt++;
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL model_pin %s: got %0d strobes, want 0", name, cnt);
    end
  endtask

  task automatic pin_model();
    pin("frame_55", f55 + 154, 1, 8'h55);
    pin("frame_a3", fa3 + 154, 1, 8'hA3);
    pin("frame_0f", f0f + 154, 1, 8'h0F);
    pin_quiet("glitch", fgl, 44);
    pin("stop_low_c4", fc4 + 154, 2, 8'h00);
    pin("frame_12", f12 + 154, 1, 8'h12);
    pin_quiet("reset_ff", fff, 180);
    pin("frame_81", f81 + 154, 1, 8'h81);
  endtask

  always @(posedge sys_clk) begin
    if (active) begin
      #1;
      checks++;
      if (bus.rx_data !== exp_data[cyc] || bus.rx_status !== ~exp_stb[cyc] ||
          bus.frame_err !== exp_err[cyc]) begin
        errors++;
        $display("FAIL outputs cycle %0d: got data=%h status=%b err=%b, want data=%h status=%b err=%b",
                 cyc, bus.rx_data, bus.rx_status, bus.frame_err,
                 exp_data[cyc], ~exp_stb[cyc], exp_err[cyc]);
      end
    end
  end

  initial begin
    reset       = 1'b0;
    bus.uart_rx = 1'b1;
    build_plan();
    run_model();
    pin_model();
    active = 1'b1;
    for (int c = 0; c < n_plan; c++) begin
      cyc         = c;
      bus.uart_rx = plan_line[c];
      reset       = plan_rst[c];
      if (c > 0 && !plan_rst[c] && plan_rst[c-1]) begin
        #1;
        checks++;
        if (bus.rx_data !== 8'h00 || bus.rx_status !== 1'b1 || bus.frame_err !== 1'b0) begin
          errors++;
          $display("FAIL async_reset cycle %0d: got data=%h status=%b err=%b, want data=00 status=1 err=0",
                   c, bus.rx_data, bus.rx_status, bus.frame_err);
        end
      end
      @(posedge sys_clk);
      #2;
    end
    active = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
